// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Serial program loader for the instruction memory. It takes a framed byte
//   stream made of a word count N, then 4N big-endian payload bytes, then an
//   XOR checksum byte. Every four payload bytes are assembled into one 32-bit
//   word, which is written to a word-aligned address. The processor is held
//   (busy) for the whole frame.
//
//   Ports:
//     clk, reset          rising-edge clock, async active-low reset
//     start               one-cycle pulse that begins a new frame
//     in_valid/in_data    byte source; a byte moves when in_valid && in_ready
//     in_ready            loader is accepting bytes (equal to busy)
//     wr_en/wr_addr/wr_data  one-cycle word write strobe, address 4*k
//     busy                frame in progress
//     done / error        sticky result of the last frame
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   COUNT  | waiting for the word-count byte N
//   DATA   | receiving 4N payload bytes and emitting words
//   CHECK  | waiting for the checksum byte
//   DONE   | frame accepted, done=1, waiting for start
//   ERROR  | frame rejected, error=1, waiting for start
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int MEM_BYTES = 72,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int         MAX_WORDS = MEM_BYTES / 4;
    localparam int         CNT_W     = $clog2(MAX_WORDS + 1);
    localparam logic [7:0] MAX_N     = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] words_left;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [7:0]       xor_sum;
    logic [23:0]      word_reg;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            words_left <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            xor_sum    <= '0;
            word_reg   <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_COUNT;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        byte_idx <= '0;
                        word_idx <= '0;
                        xor_sum  <= '0;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        if (in_data == 8'd0 || in_data > MAX_N) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            words_left <= in_data[CNT_W-1:0];
                            state      <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        word_reg <= {word_reg[15:0], in_data};
                        xor_sum  <= xor_sum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // word complete: strobe it out on the next cycle
                            wr_en      <= 1'b1;
                            wr_addr    <= ADDR_W'({word_idx, 2'b00});
                            wr_data    <= {word_reg, in_data};
                            word_idx   <= word_idx + CNT_W'(1);
                            words_left <= words_left - CNT_W'(1);
                            if (words_left == CNT_W'(1)) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        if (in_data == xor_sum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. A frame-level reference model tracks
//   the position inside the current frame and derives the expected writes,
//   busy and result flags from the frame bytes themselves.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int MEM_BYTES = 72;
    localparam int ADDR_W    = 32;
    localparam int MAX_WORDS = MEM_BYTES / 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    logic              m_err  = 1'b0;
    int                m_pos  = 0;
    int                m_n    = 0;
    logic [7:0]        m_xor  = 8'h00;
    logic [7:0]        m_pay [0:MEM_BYTES-1];
    logic              exp_wr = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;

    logic [7:0]        frame [$];

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic model_consume(input logic [7:0] d);
        if (m_pos == 0) begin
            m_n = int'(d);
            if (m_n == 0 || m_n > MAX_WORDS) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end else begin
                m_pos = 1;
            end
        end else if (m_pos <= 4 * m_n) begin
            m_pay[m_pos-1] = d;
            m_xor = m_xor ^ d;
            if (m_pos % 4 == 0) begin
                exp_wr    = 1'b1;
                last_addr = ADDR_W'(m_pos - 4);
                last_data = {m_pay[m_pos-4], m_pay[m_pos-3], m_pay[m_pos-2], m_pay[m_pos-1]};
            end
            m_pos = m_pos + 1;
        end else begin
            m_busy = 1'b0;
            m_done = (d == m_xor);
            m_err  = (d != m_xor);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs, then
    // advance the model past the rising edge.
    task automatic step(input logic st, input logic v, input logic [7:0] d);
        logic acc;
        @(negedge clk);
        total++;
        if (wr_en !== exp_wr) begin
            bad++; $display("FAIL wr_en got=%b want=%b t=%0t", wr_en, exp_wr, $time);
        end
        total++;
        if (wr_addr !== last_addr) begin
            bad++; $display("FAIL wr_addr got=%h want=%h t=%0t", wr_addr, last_addr, $time);
        end
        total++;
        if (wr_data !== last_data) begin
            bad++; $display("FAIL wr_data got=%h want=%h t=%0t", wr_data, last_data, $time);
        end
        total++;
        if (busy !== m_busy) begin
            bad++; $display("FAIL busy got=%b want=%b t=%0t", busy, m_busy, $time);
        end
        total++;
        if (in_ready !== m_busy) begin
            bad++; $display("FAIL in_ready got=%b want=%b t=%0t", in_ready, m_busy, $time);
        end
        total++;
        if (done !== m_done) begin
            bad++; $display("FAIL done got=%b want=%b t=%0t", done, m_done, $time);
        end
        total++;
        if (error !== m_err) begin
            bad++; $display("FAIL error got=%b want=%b t=%0t", error, m_err, $time);
        end
        start    = st;
        in_valid = v;
        in_data  = d;
        acc = v && m_busy;
        @(posedge clk);
        exp_wr = 1'b0;
        if (st && !m_busy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_pos  = 0;
            m_xor  = 8'h00;
        end else if (acc) begin
            model_consume(d);
        end
    endtask

    task automatic build_frame(input int n, input logic corrupt);
        logic [7:0] x;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        x = 8'h00;
        if (n >= 1 && n <= MAX_WORDS) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                frame.push_back(b);
            end
            frame.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
        end
    endtask

    task automatic plan_frame(input logic [7:0] csum);
        frame.delete();
        frame.push_back(8'h02);
        frame.push_back(8'h08); frame.push_back(8'h00); frame.push_back(8'h00); frame.push_back(8'h05);
        frame.push_back(8'h00); frame.push_back(8'h43); frame.push_back(8'h08); frame.push_back(8'h20);
        frame.push_back(csum);
    endtask

    // mode 0: continuous, 1: in_valid toggles, 2: random gaps.
    // start is re-pulsed alongside byte start_at (ignored by a busy loader).
    task automatic send_frame(input int mode, input int start_at);
        int i;
        bit ph;
        bit gap;
        step(1'b1, 1'b0, 8'h00);
        i  = 0;
        ph = 1'b0;
        while (i < frame.size()) begin
            gap = (mode == 1) ? ph : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            ph  = !ph;
            if (gap) begin
                step(1'b0, 1'b0, 8'($urandom));
            end else begin
                step(i == start_at, 1'b1, frame[i]);
                i++;
            end
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, wr_en, busy, done, error} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {in_ready, wr_en, busy, done, error});
        end
        total++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            bad++; $display("FAIL reset_bus got=%h/%h want=0/0", wr_addr, wr_data);
        end
        reset = 1'b1;
        step(1'b0, 1'b1, 8'h02);   // not busy: byte must be ignored
    endtask

    task automatic test_good;
        plan_frame(8'h66);
        send_frame(0, -1);
        total++;
        if (wr_addr !== 32'h4 || wr_data !== 32'h00430820) begin
            bad++; $display("FAIL good_last_write got=%h/%h want=4/00430820", wr_addr, wr_data);
        end
        total++;
        if ({done, error, busy} !== 3'b100) begin
            bad++; $display("FAIL good_flags got=%b want=100", {done, error, busy});
        end
    endtask

    task automatic test_bad_checksum;
        plan_frame(8'h67);
        send_frame(0, -1);
        total++;
        if ({done, error} !== 2'b01) begin
            bad++; $display("FAIL badsum_flags got=%b want=01", {done, error});
        end
    endtask

    task automatic test_illegal_count;
        build_frame(0, 1'b0);
        send_frame(0, -1);
        build_frame(19, 1'b0);
        send_frame(2, -1);
        total++;
        if (error !== 1'b1) begin
            bad++; $display("FAIL illegal_count error got=%b want=1", error);
        end
    endtask

    task automatic test_throttled;
        plan_frame(8'h66);
        send_frame(1, -1);
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL throttled_done got=%b want=1", done);
        end
    endtask

    task automatic test_reset_mid;
        plan_frame(8'h66);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, frame[i]);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({in_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            bad++; $display("FAIL reset_mid got=%b %h %h want=00000 0 0",
                            {in_ready, wr_en, busy, done, error}, wr_addr, wr_data);
        end
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; exp_wr = 1'b0;
        last_addr = '0; last_data = '0;
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        send_frame(0, -1);
    endtask

    task automatic test_start_busy;
        plan_frame(8'h66);
        send_frame(0, 3);
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL start_busy_done got=%b want=1", done);
        end
    endtask

    task automatic test_random;
        int n;
        for (int f = 0; f < 14; f++) begin
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(19, 255)) : int'($urandom_range(1, MAX_WORDS));
            build_frame(n, $urandom_range(0, 2) == 0);
            send_frame(2, ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : -1);
        end
        build_frame(MAX_WORDS, 1'b0);
        send_frame(0, -1);
    endtask

    initial begin
        test_reset;
        test_good;
        test_bad_checksum;
        test_illegal_count;
        test_throttled;
        test_reset_mid;
        test_start_busy;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
